// File: rtl/snake_direction_ctrl.sv
// snake_direction_ctrl: turns button presses into queued, tick-paced snake direction changes
module snake_direction_ctrl #(
    parameter int          QUEUE_DEPTH = 2,
    parameter int          TICK_DIV    = 25000000,
    parameter logic [1:0]  INIT_DIR    = 2'b00,
    localparam int         LW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [3:0]    push_buttons,
    input  logic          pause,
    output logic [1:0]    dir_out,
    output logic          move_tick,
    output logic [LW-1:0] queue_level,
    output logic          reject
);
    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(TICK_DIV);

    logic [3:0]    sync1, sync2, sync3, press;
    logic [2:0]    live;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rd_ptr, wr_ptr, last;
    logic [1:0]    fifo [QUEUE_DEPTH];
    logic [1:0]    req, tail;
    logic          wrap, pop, push;

    // Press selection and accept/reject decision; the first sample after reset is
    // compared against reset flops, so presses are masked until a real prior sample exists
    always_comb begin
        press = live[2] ? sync2 & ~sync3 : 4'b0;
        req   = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
        last  = wr_ptr == '0 ? PW'(QUEUE_DEPTH - 1) : wr_ptr - PW'(1);
        tail  = queue_level != '0 ? fifo[last] : dir_out;
        wrap  = !pause && cnt == CW'(TICK_DIV - 1);
        pop   = wrap && queue_level != '0;
        push  = |press && (^req != ^tail) && queue_level != LW'(QUEUE_DEPTH);
    end

    // Synchroniser, tick counter, queue bookkeeping and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sync3       <= '0;
            live        <= '0;
            cnt         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_level <= '0;
            dir_out     <= INIT_DIR;
            move_tick   <= 1'b0;
            reject      <= 1'b0;
        end else begin
            sync1       <= push_buttons;
            sync2       <= sync1;
            sync3       <= sync2;
            live        <= {live[1:0], 1'b1};
            cnt         <= wrap ? '0 : pause ? cnt : cnt + CW'(1);
            move_tick   <= wrap;
            reject      <= |press && !push;
            queue_level <= queue_level + LW'(push) - LW'(pop);
            if (pop) begin
                dir_out <= fifo[rd_ptr];
                rd_ptr  <= rd_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        end
    end

    // Queue storage needs no reset: entries are only read when counted valid
    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= req;
    end
endmodule

// File: tb/tb_snake_direction_ctrl.sv
// tb_snake_direction_ctrl: directed and random checks against a queue-based reference model
module tb_snake_direction_ctrl;
    localparam int TD = 4;
    localparam int QD = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] push_buttons = 4'b0;
    logic       pause = 1'b0;
    logic [1:0] dir_out;
    logic       move_tick;
    logic [1:0] queue_level;
    logic       reject;

    int checks = 0;
    int errors = 0;

    snake_direction_ctrl #(.QUEUE_DEPTH(QD), .TICK_DIV(TD), .INIT_DIR(2'b00)) dut (
        .clock(clock), .reset_n(reset_n), .push_buttons(push_buttons), .pause(pause),
        .dir_out(dir_out), .move_tick(move_tick), .queue_level(queue_level), .reject(reject)
    );

    always #5 clock = ~clock;

    // Reference model: queue of pending directions, tick counter as an integer,
    // and the history of button samples taken since reset release
    int         m_cnt = 0;
    int         m_dir = 0;
    int         mq[$];
    logic       m_tick = 1'b0;
    logic       m_rej = 1'b0;
    logic [3:0] hq[$];

    always @(posedge clock or negedge reset_n) begin : mdl
        int         tail, rd;
        logic       wrap, acc;
        logic [3:0] pr;
        if (!reset_n) begin
            m_cnt = 0; m_dir = 0; mq.delete(); m_tick = 0; m_rej = 0; hq.delete();
        end else begin
            wrap = !pause && m_cnt == TD - 1;
            pr   = hq.size() >= 3 ? hq[hq.size()-2] & ~hq[hq.size()-3] : 4'b0;
            tail = mq.size() > 0 ? mq[mq.size()-1] : m_dir;
            acc  = 0;
            m_rej = 0;
            rd   = 0;
            if (pr != 0) begin
                for (int b = 3; b >= 0; b--) if (pr[b]) rd = b;
                acc   = ((rd % 3 == 0) != (tail % 3 == 0)) && mq.size() < QD;
                m_rej = !acc;
            end
            if (wrap && mq.size() > 0) m_dir = mq.pop_front();
            if (acc) mq.push_back(rd);
            m_cnt  = wrap ? 0 : pause ? m_cnt : m_cnt + 1;
            m_tick = wrap;
            hq.push_back(push_buttons);
            if (hq.size() > 3) void'(hq.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            chk("dir", dir_out, m_dir);
            chk("tick", move_tick, m_tick);
            chk("level", queue_level, mq.size());
            chk("reject", reject, m_rej);
        end
    endtask

    task automatic rst_cycle();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // reset and free-running ticks
        cyc(2);
        chk("rst_dir", dir_out, 0);
        chk("rst_level", queue_level, 0);
        reset_n = 1'b1;
        cyc(3);
        chk("no_tick3", move_tick, 0);
        cyc(1);
        chk("tick4", move_tick, 1);
        cyc(4);
        chk("tick8", move_tick, 1);
        cyc(4);
        chk("tick12", move_tick, 1);
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_dir", dir_out, 0);
        chk("async_tick", move_tick, 0);
        chk("async_level", queue_level, 0);
        chk("async_reject", reject, 0);
        cyc(1);
        reset_n = 1'b1;

        // up accepted, applied on the next tick
        cyc(2);
        push_buttons = 4'b0100;
        cyc(3);
        chk("up_level", queue_level, 1);
        push_buttons = 4'b0;
        cyc(3);
        chk("up_dir", dir_out, 2);
        chk("up_level0", queue_level, 0);

        // left and right from right are rejected
        rst_cycle();
        cyc(2);
        push_buttons = 4'b1000;
        cyc(3);
        chk("left_rej", reject, 1);
        push_buttons = 4'b0;
        cyc(2);
        push_buttons = 4'b0001;
        cyc(3);
        chk("right_rej", reject, 1);
        push_buttons = 4'b0;
        cyc(1);
        chk("rej_level", queue_level, 0);
        chk("rej_dir", dir_out, 0);

        // down then left in one period, then a repeated left
        rst_cycle();
        cyc(2);
        push_buttons = 4'b0010; cyc(1);
        push_buttons = 4'b0;    cyc(1);
        push_buttons = 4'b1000; cyc(1);
        push_buttons = 4'b0;    cyc(2);
        chk("two_level", queue_level, 2);
        cyc(1);
        chk("two_dir1", dir_out, 1);
        cyc(4);
        chk("two_dir2", dir_out, 3);
        chk("two_empty", queue_level, 0);
        push_buttons = 4'b1000; cyc(1);
        push_buttons = 4'b0;    cyc(2);
        chk("repeat_rej", reject, 1);

        // full queue, then simultaneous right+down with dir up
        rst_cycle();
        cyc(2);
        push_buttons = 4'b0010; cyc(1);
        push_buttons = 4'b1000; cyc(1);
        push_buttons = 4'b0100; cyc(1);
        push_buttons = 4'b0;    cyc(2);
        chk("full_rej", reject, 1);
        chk("full_level", queue_level, 2);
        cyc(5);
        push_buttons = 4'b0100; cyc(1);
        push_buttons = 4'b0;    cyc(3);
        chk("to_up_dir", dir_out, 2);
        push_buttons = 4'b0011; cyc(1);
        push_buttons = 4'b0;    cyc(2);
        chk("multi_level", queue_level, 1);
        chk("multi_norej", reject, 0);
        cyc(1);
        chk("multi_dir", dir_out, 0);

        // pause holds ticks, presses still queue
        rst_cycle();
        cyc(2);
        push_buttons = 4'b0010; cyc(1);
        push_buttons = 4'b0;    cyc(2);
        pause = 1'b1;
        push_buttons = 4'b1000; cyc(1);
        push_buttons = 4'b0;    cyc(9);
        chk("pause_level", queue_level, 2);
        chk("pause_dir", dir_out, 0);
        pause = 1'b0;
        cyc(3);
        chk("resume_dir1", dir_out, 1);
        cyc(4);
        chk("resume_dir2", dir_out, 3);

        // button held through reset release
        push_buttons = 4'b0100;
        rst_cycle();
        cyc(6);
        chk("held_level", queue_level, 0);
        push_buttons = 4'b0;    cyc(2);
        push_buttons = 4'b0100; cyc(3);
        chk("repress_level", queue_level, 1);
        push_buttons = 4'b0;

        // random buttons and pause against the model
        rst_cycle();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) push_buttons = 4'($urandom);
            pause = $urandom_range(0, 5) == 0;
            if (i == 300) rst_cycle();
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_direction_ctrl.md
# snake_direction_ctrl

Parametrised direction controller for the snake game. It converts raw push-button levels into direction changes, paced by an internal move tick. Turn requests are synchronised, edge-detected and filtered so that no reversal or repeat is accepted. Accepted turns are buffered in a small FIFO, so quick turn sequences made within one move period are applied on consecutive ticks. Its outputs feed the snake position/update logic directly.

## Interface
- QUEUE_DEPTH, 2: number of buffered turn requests (≥1).
- TICK_DIV, 25000000: clock cycles per move tick (≥2).
- INIT_DIR, 2'b00: direction loaded at reset.
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PUSH_BUTTONS  in  4  raw, asynchronous button levels. Bit 0 right, bit 1 down, bit 2 up, bit 3 left.
- PAUSE  in  1  synchronous; high freezes tick generation.
- DIR_OUT  out  2  current direction. 00 right, 01 down, 10 up, 11 left.
- MOVE_TICK  out  1  one-cycle pulse per move step.
- QUEUE_LEVEL  out  $clog2(QUEUE_DEPTH+1)  number of buffered turns.
- REJECT  out  1  one-cycle pulse when a detected press is discarded.

## Operation
- Input path: two-flop synchroniser per button, then a third flop for edge detection. A press is sync2 & ~sync3.
- Multiple presses in one cycle: only one request is taken, priority bit0 > bit1 > bit2 > bit3. The lower-priority presses are silently ignored and do not trigger REJECT.
- Tail direction: the last queue entry if QUEUE_LEVEL>0, otherwise DIR_OUT. It is evaluated before any same-cycle pop.
- A request is accepted only if it is perpendicular to the tail direction. Horizontal directions are 00/11; vertical directions are 01/10.
- A request is rejected, with a REJECT pulse, in either case:
  - it is the same as or opposite to the tail direction;
  - it is valid but QUEUE_LEVEL==QUEUE_DEPTH (full), even if a pop happens in the same cycle.
- Tick counter:
  - Counts 0..TICK_DIV-1 while PAUSE=0 and holds its value while PAUSE=1.
  - On the edge where it wraps from TICK_DIV-1 to 0:
    - MOVE_TICK is set to 1 for one cycle;
    - if the queue is non-empty, DIR_OUT loads the head entry and the head is popped.
- Simultaneous push and pop: both occur and QUEUE_LEVEL is unchanged. FIFO pointers wrap modulo QUEUE_DEPTH.
- Presses are accepted and rejected normally during PAUSE. Only popping stops.
- Reset, at any time and including mid-operation, applies these values:
  - DIR_OUT=INIT_DIR;
  - MOVE_TICK=0, REJECT=0, QUEUE_LEVEL=0;
  - counter=0;
  - synchroniser and edge flops=0;
  - FIFO pointers=0.
- A button held through reset release does not generate a press until it is released and pressed again. It does generate one if it is first seen low after reset.

## Timing
- Press latency:
  - button first sampled high at edge k;
  - enqueue/REJECT decision at edge k+2;
  - QUEUE_LEVEL/REJECT visible in cycle k+2..k+3.
- DIR_OUT and MOVE_TICK change on the same edge. During the MOVE_TICK-high cycle, DIR_OUT already shows the new direction.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.
- First MOVE_TICK after reset release: TICK_DIV edges later, then every TICK_DIV cycles while unpaused.
- PAUSE asserted in the cycle before a wrap suppresses that tick. Counting resumes from the held value.
- Holding a button creates exactly one press. Releasing it and pressing again creates a new press.

## Test plan
Parameters for all scenarios: TICK_DIV=4, QUEUE_DEPTH=2, INIT_DIR=00.
- Reset, no buttons: DIR_OUT=00 and QUEUE_LEVEL=0. MOVE_TICK pulses on cycles 4, 8, 12 after release. Assert RESET_N low mid-count: all outputs return to reset values immediately.
- From 00, press bit2 (up): QUEUE_LEVEL=1 two edges after sampling. At the next tick, DIR_OUT=10 and QUEUE_LEVEL=0.
- From 00, press bit3 (left), then bit0 (right): each gives a REJECT pulse; QUEUE_LEVEL stays 0 and DIR_OUT stays 00.
- From 00, press down, then left, within one period: QUEUE_LEVEL=2. Tick 1 gives DIR_OUT=01; tick 2 gives DIR_OUT=11. A subsequent left press is rejected because it repeats the tail.
- Full queue: down, left, then up before any tick. Up is perpendicular to the tail but the queue is full, so REJECT pulses and QUEUE_LEVEL stays 2. Press bit0+bit1 in the same cycle with the queue empty and DIR_OUT=10: only right is enqueued.
- PAUSE=1 for 10 cycles with 1 entry queued: no MOVE_TICK and DIR_OUT unchanged. A valid press during pause gives QUEUE_LEVEL=2. After PAUSE=0, the counter resumes from its held value and entries pop on successive ticks.
